// File: rtl/cu_pkg.sv
// Shared types and constants for the control sequencer: state encoding,
// opcodes, ALU select codes, register bank addresses and the control word.
package cu_pkg;

   typedef enum logic [3:0] {
      S_INIT, S_F0, S_F1, S_F2, S_DEC,
      S_X_INV, S_X_INC, S_X_ADD, S_X_SHL, S_X_JZ,
      S_M0, S_M1, S_M2, S_HALT
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_INV  = 5'h01;
   localparam logic [4:0] OP_INC  = 5'h02;
   localparam logic [4:0] OP_ADD  = 5'h03;
   localparam logic [4:0] OP_LDA  = 5'h04;
   localparam logic [4:0] OP_STA  = 5'h05;
   localparam logic [4:0] OP_JZ   = 5'h06;
   localparam logic [4:0] OP_SHL  = 5'h07;
   localparam logic [4:0] OP_HALT = 5'h1F;

   localparam logic [2:0] SEL_PASS = 3'b000;
   localparam logic [2:0] SEL_NOT  = 3'b001;
   localparam logic [2:0] SEL_INC  = 3'b010;
   localparam logic [2:0] SEL_ADD  = 3'b011;
   localparam logic [2:0] SEL_AND  = 3'b100;
   localparam logic [2:0] SEL_OR   = 3'b101;
   localparam logic [2:0] SEL_SHL  = 3'b110;
   localparam logic [2:0] SEL_MDR  = 3'b111;

   localparam logic [2:0] R_PC   = 3'd0;
   localparam logic [2:0] R_DPTR = 3'd1;
   localparam logic [2:0] R_A    = 3'd2;
   localparam logic [2:0] R_TEMP = 3'd3;
   localparam logic [2:0] R_ACC  = 3'd7;

   // One field per control output of the top level.
   typedef struct packed {
      logic       ir_sclr;
      logic       mar_sclr;
      logic       enaf;
      logic [2:0] selop;
      logic [1:0] shamt;
      logic       bank_wr_en;
      logic [2:0] busB_addr;
      logic [2:0] busC_addr;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic       wr_rdn;
      logic       mdr_alu_n;
      logic       halted;
      logic       illegal;
   } ctrl_word_t;

endpackage

// File: rtl/cu_ctrl_decode.sv
// Combinational microcode table: {state, opcode, Z} -> control word.
module cu_ctrl_decode
   import cu_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   input  logic       z,
   output ctrl_word_t cw
);

   // Everything defaults to 0; each state raises only its own controls.
   always_comb begin
      cw = '0;
      case (state)
         S_INIT: begin
            cw.ir_sclr  = 1'b1;
            cw.mar_sclr = 1'b1;
         end
         S_F0: begin
            cw.busB_addr = R_PC;
            cw.selop     = SEL_PASS;
            cw.mar_en    = 1'b1;
         end
         S_F1: begin
            cw.mdr_en    = 1'b1;
            cw.mdr_alu_n = 1'b1;
         end
         // IR loads straight from MDR, so the ALU is free to bump the PC.
         S_F2: begin
            cw.ir_en      = 1'b1;
            cw.busB_addr  = R_PC;
            cw.selop      = SEL_INC;
            cw.busC_addr  = R_PC;
            cw.bank_wr_en = 1'b1;
         end
         S_DEC: begin
            case (opcode)
               OP_NOP, OP_INV, OP_INC, OP_ADD, OP_LDA,
               OP_STA, OP_JZ, OP_SHL, OP_HALT: cw.illegal = 1'b0;
               default:                        cw.illegal = 1'b1;
            endcase
         end
         S_X_INV, S_X_INC: begin
            cw.busB_addr  = R_ACC;
            cw.selop      = (state == S_X_INV) ? SEL_NOT : SEL_INC;
            cw.busC_addr  = R_ACC;
            cw.bank_wr_en = 1'b1;
            cw.enaf       = 1'b1;
         end
         S_X_ADD: begin
            cw.busB_addr  = R_A;
            cw.selop      = SEL_ADD;
            cw.busC_addr  = R_ACC;
            cw.bank_wr_en = 1'b1;
            cw.enaf       = 1'b1;
         end
         S_X_SHL: begin
            cw.busB_addr  = R_ACC;
            cw.selop      = SEL_SHL;
            cw.shamt      = 2'b01;
            cw.busC_addr  = R_ACC;
            cw.bank_wr_en = 1'b1;
            cw.enaf       = 1'b1;
         end
         // Taken branch copies DPTR into PC; not taken is a dead cycle.
         S_X_JZ: begin
            if (z) begin
               cw.busB_addr  = R_DPTR;
               cw.selop      = SEL_PASS;
               cw.busC_addr  = R_PC;
               cw.bank_wr_en = 1'b1;
            end
         end
         S_M0: begin
            cw.busB_addr = R_DPTR;
            cw.selop     = SEL_PASS;
            cw.mar_en    = 1'b1;
         end
         S_M1: begin
            cw.mdr_en = 1'b1;
            if (opcode == OP_STA) begin
               cw.busB_addr = R_ACC;
               cw.selop     = SEL_PASS;
            end else begin
               cw.mdr_alu_n = 1'b1;
            end
         end
         S_M2: begin
            if (opcode == OP_STA) begin
               cw.wr_rdn = 1'b1;
            end else begin
               cw.selop      = SEL_MDR;
               cw.busC_addr  = R_A;
               cw.bank_wr_en = 1'b1;
            end
         end
         S_HALT: cw.halted = 1'b1;
         default: cw = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for memory_system. Holds the state and
// latched opcode; the control word comes from cu_ctrl_decode.
module control_unit
   import cu_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] instruction,
   input  logic       C,
   input  logic       N,
   input  logic       P,
   input  logic       Z,
   output logic       ir_sclr,
   output logic       mar_sclr,
   output logic       enaf,
   output logic [2:0] selop,
   output logic [1:0] shamt,
   output logic       bank_wr_en,
   output logic [2:0] busB_addr,
   output logic [2:0] busC_addr,
   output logic       ir_en,
   output logic       mar_en,
   output logic       mdr_en,
   output logic       wr_rdn,
   output logic       mdr_alu_n,
   output logic       halted,
   output logic       illegal
);

   // Only Z steers sequencing; the other flags and the width are carried
   // for interface symmetry with the datapath.
   localparam int unused_dw = DATA_WIDTH;
   logic unused_flags;
   assign unused_flags = ^{C, N, P};

   state_t     state_q, state_d;
   logic [4:0] opc_q;
   logic [4:0] op_eff;
   ctrl_word_t cw;

   // State register; reset drops straight into INIT mid-instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_INIT;
      else     state_q <= state_d;
   end

   // Opcode is captured on leaving DEC so execute/memory states ignore IR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  opc_q <= OP_NOP;
      else if (state_q == S_DEC) opc_q <= instruction;
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT: state_d = S_F0;
         S_F0:   state_d = S_F1;
         S_F1:   state_d = S_F2;
         S_F2:   state_d = S_DEC;
         S_DEC: begin
            case (instruction)
               OP_INV:       state_d = S_X_INV;
               OP_INC:       state_d = S_X_INC;
               OP_ADD:       state_d = S_X_ADD;
               OP_LDA,
               OP_STA:       state_d = S_M0;
               OP_JZ:        state_d = S_X_JZ;
               OP_SHL:       state_d = S_X_SHL;
               OP_HALT:      state_d = S_HALT;
               default:      state_d = S_F0;
            endcase
         end
         S_X_INV, S_X_INC, S_X_ADD, S_X_SHL, S_X_JZ: state_d = S_F0;
         S_M0:   state_d = S_M1;
         S_M1:   state_d = S_M2;
         S_M2:   state_d = S_F0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   // In DEC the opcode register has not loaded yet, so decode sees IR live.
   assign op_eff = (state_q == S_DEC) ? instruction : opc_q;

   cu_ctrl_decode u_dec (
      .state  (state_q),
      .opcode (op_eff),
      .z      (Z),
      .cw     (cw)
   );

   assign ir_sclr    = cw.ir_sclr;
   assign mar_sclr   = cw.mar_sclr;
   assign enaf       = cw.enaf;
   assign selop      = cw.selop;
   assign shamt      = cw.shamt;
   assign bank_wr_en = cw.bank_wr_en;
   assign busB_addr  = cw.busB_addr;
   assign busC_addr  = cw.busC_addr;
   assign ir_en      = cw.ir_en;
   assign mar_en     = cw.mar_en;
   assign mdr_en     = cw.mdr_en;
   assign wr_rdn     = cw.wr_rdn;
   assign mdr_alu_n  = cw.mdr_alu_n;
   assign halted     = cw.halted;
   assign illegal    = cw.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks every instruction class cycle by
// cycle and compares the full control word against hand-built values.
module tb_control_unit;

   typedef struct packed {
      logic       ir_sclr;
      logic       mar_sclr;
      logic       enaf;
      logic [2:0] selop;
      logic [1:0] shamt;
      logic       bank_wr_en;
      logic [2:0] busB_addr;
      logic [2:0] busC_addr;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic       wr_rdn;
      logic       mdr_alu_n;
      logic       halted;
      logic       illegal;
   } ow_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] instruction;
   logic       C, N, P, Z;
   logic       ir_sclr, mar_sclr, enaf, bank_wr_en;
   logic [2:0] selop, busB_addr, busC_addr;
   logic [1:0] shamt;
   logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted, illegal;
   ow_t        obs;

   int n_chk  = 0;
   int n_pass = 0;

   control_unit #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .instruction(instruction),
      .C(C), .N(N), .P(P), .Z(Z),
      .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf),
      .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en),
      .busB_addr(busB_addr), .busC_addr(busC_addr),
      .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
      .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign obs = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en,
                 busB_addr, busC_addr, ir_en, mar_en, mdr_en, wr_rdn,
                 mdr_alu_n, halted, illegal};

   task automatic chk(input string tag, input ow_t e);
      n_chk++;
      assert (obs === e) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, e);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   ow_t w_zero, w_init, w_f0, w_f1, w_f2, w_ill;
   ow_t w_inv, w_inc, w_add, w_shl, w_jz1;
   ow_t w_m0, w_m1l, w_m2l, w_m1s, w_m2s, w_halt;

   // Checks F0..DEC of one fetch with the given opcode presented on IR.
   task automatic fetch(input logic [4:0] op, input ow_t dec_exp, input string tag);
      instruction = op;
      chk({tag, "_f0"}, w_f0);
      step(); chk({tag, "_f1"}, w_f1);
      step(); chk({tag, "_f2"}, w_f2);
      step(); chk({tag, "_dec"}, dec_exp);
   endtask

   initial begin
      w_zero = '0;
      w_init = '0; w_init.ir_sclr = 1; w_init.mar_sclr = 1;
      w_f0 = '0; w_f0.busB_addr = 0; w_f0.selop = 3'b000; w_f0.mar_en = 1;
      w_f1 = '0; w_f1.mdr_en = 1; w_f1.mdr_alu_n = 1;
      w_f2 = '0; w_f2.ir_en = 1; w_f2.busB_addr = 0; w_f2.selop = 3'b010;
      w_f2.busC_addr = 0; w_f2.bank_wr_en = 1;
      w_ill = '0; w_ill.illegal = 1;
      w_inv = '0; w_inv.busB_addr = 7; w_inv.selop = 3'b001; w_inv.busC_addr = 7;
      w_inv.bank_wr_en = 1; w_inv.enaf = 1;
      w_inc = w_inv; w_inc.selop = 3'b010;
      w_add = '0; w_add.busB_addr = 2; w_add.selop = 3'b011; w_add.busC_addr = 7;
      w_add.bank_wr_en = 1; w_add.enaf = 1;
      w_shl = w_inv; w_shl.selop = 3'b110; w_shl.shamt = 2'b01;
      w_jz1 = '0; w_jz1.busB_addr = 1; w_jz1.busC_addr = 0; w_jz1.bank_wr_en = 1;
      w_m0 = '0; w_m0.busB_addr = 1; w_m0.mar_en = 1;
      w_m1l = '0; w_m1l.mdr_en = 1; w_m1l.mdr_alu_n = 1;
      w_m2l = '0; w_m2l.selop = 3'b111; w_m2l.busC_addr = 2; w_m2l.bank_wr_en = 1;
      w_m1s = '0; w_m1s.busB_addr = 7; w_m1s.mdr_en = 1;
      w_m2s = '0; w_m2s.wr_rdn = 1;
      w_halt = '0; w_halt.halted = 1;

      instruction = 5'h00; C = 0; N = 0; P = 0; Z = 0;

      // Reset: INIT word appears asynchronously and holds through edges.
      rst = 1'b1;
      #1 chk("rst_async", w_init);
      repeat (2) @(negedge clk);
      chk("rst_hold", w_init);
      rst = 1'b0;
      step();

      // INV; IR changes after DEC to show execute uses the latched opcode.
      fetch(5'h01, w_zero, "inv");
      step(); instruction = 5'h03; chk("inv_x", w_inv);
      step(); chk("inv_back_f0", w_f0);

      fetch(5'h02, w_zero, "inc");
      step(); chk("inc_x", w_inc);
      step();
      fetch(5'h03, w_zero, "add");
      step(); chk("add_x", w_add);
      step();
      fetch(5'h07, w_zero, "shl");
      step(); chk("shl_x", w_shl);
      step();

      // JZ taken and not taken.
      Z = 1'b1;
      fetch(5'h06, w_zero, "jz1");
      step(); chk("jz1_x", w_jz1);
      step();
      Z = 1'b0;
      fetch(5'h06, w_zero, "jz0");
      step(); chk("jz0_x", w_zero);
      step();

      // LDA, with IR switched to STA mid-op.
      fetch(5'h04, w_zero, "lda");
      step(); instruction = 5'h05; chk("lda_m0", w_m0);
      step(); chk("lda_m1", w_m1l);
      step(); chk("lda_m2", w_m2l);
      step();
      fetch(5'h05, w_zero, "sta");
      step(); chk("sta_m0", w_m0);
      step(); chk("sta_m1", w_m1s);
      step(); chk("sta_m2", w_m2s);
      step();

      // NOP and illegal opcode: DEC then straight back to F0.
      fetch(5'h00, w_zero, "nop");
      step();
      fetch(5'h0A, w_ill, "ill");
      step(); chk("ill_back_f0", w_f0);

      // Reset during M1 of STA: INIT at once, no store cycle afterwards.
      fetch(5'h05, w_zero, "sta2");
      step(); chk("sta2_m0", w_m0);
      step(); chk("sta2_m1", w_m1s);
      rst = 1'b1;
      #1 chk("midrst_async", w_init);
      for (int i = 0; i < 3; i++) begin
         step(); chk("midrst_hold", w_init);
      end
      rst = 1'b0;
      step();

      // HALT persists until reset.
      fetch(5'h1F, w_zero, "halt");
      for (int i = 0; i < 20; i++) begin
         step(); chk("halt_hold", w_halt);
      end
      rst = 1'b1;
      #1 chk("halt_rst", w_init);
      @(negedge clk);
      rst = 1'b0;
      step(); chk("post_halt_f0", w_f0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
